// File: rtl/alu_operand_loader.sv
// Byte-serial operand sequencer for the 8-bit ALU: gathers A, B and the selector
// over one byte bus and offers them as a registered set with a valid/ready handshake.
module alu_operand_loader #(
   parameter int SEL_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       data_in,
   input  logic             wr_en,
   input  logic             clr,
   output logic [7:0]       a_out,
   output logic [7:0]       b_out,
   output logic [SEL_W-1:0] sel_out,
   output logic             op_valid,
   input  logic             op_ready,
   output logic             busy,
   output logic             ovf,
   output logic [1:0]       phase
);

   typedef enum logic [1:0] {
      S_A    = 2'b00,
      S_B    = 2'b01,
      S_OP   = 2'b10,
      S_HOLD = 2'b11
   } state_t;

   typedef struct packed {
      logic [7:0]       a;
      logic [7:0]       b;
      logic [SEL_W-1:0] sel;
   } opset_t;

   state_t state, state_nxt;
   opset_t opset;
   logic   ld_a, ld_b, ld_sel, drop;

   always_ff @(posedge clk) begin
      if (rst) state <= S_A;
      else     state <= state_nxt;
   end

   // clr wins over any byte or handshake in the same cycle, so all load strobes stay low
   always_comb begin
      state_nxt = state;
      ld_a      = 1'b0;
      ld_b      = 1'b0;
      ld_sel    = 1'b0;
      drop      = 1'b0;
      if (clr) begin
         state_nxt = S_A;
      end else begin
         case (state)
            S_A: if (wr_en) begin
               ld_a      = 1'b1;
               state_nxt = S_B;
            end
            S_B: if (wr_en) begin
               ld_b      = 1'b1;
               state_nxt = S_OP;
            end
            S_OP: if (wr_en) begin
               ld_sel    = 1'b1;
               state_nxt = S_HOLD;
            end
            S_HOLD: begin
               if (op_ready) begin
                  ld_a      = wr_en;
                  state_nxt = wr_en ? S_B : S_A;
               end else begin
                  drop = wr_en;
               end
            end
            default: state_nxt = S_A;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         opset <= '0;
         ovf   <= 1'b0;
      end else begin
         if (ld_a)   opset.a   <= data_in;
         if (ld_b)   opset.b   <= data_in;
         if (ld_sel) opset.sel <= data_in[SEL_W-1:0];
         if (clr)       ovf <= 1'b0;
         else if (drop) ovf <= 1'b1;
      end
   end

   always_comb begin
      op_valid = (state == S_HOLD);
      busy     = (state != S_A);
      phase    = state;
      a_out    = opset.a;
      b_out    = opset.b;
      sel_out  = opset.sel;
   end

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Byte-serial operand sequencer that sits directly upstream of the 8-bit ALU. It collects operand A, operand B and the operation selector over the shared 8-bit input pins, one byte per write strobe. It then presents all three as stable registered values with a valid/ready handshake. This lets A, B and ALU_Sel come from the same pin group, with no overlap between B and the selector bits.

## Interface
- SEL_W, default 3: width of the ALU operation selector taken from the third byte.

- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- data_in  input  8  byte bus from the input pins.
- wr_en  input  1  byte write strobe; each cycle it is high counts as one byte.
- clr  input  1  synchronous abort of a partial load; lower priority than rst.
- a_out  output  8  registered operand A to the ALU.
- b_out  output  8  registered operand B to the ALU.
- sel_out  output  SEL_W  registered ALU selector.
- op_valid  output  1  A, B and sel_out are complete and stable.
- op_ready  input  1  the consumer accepts the current operand set.
- busy  output  1  a load is in progress, or an operand set is held.
- ovf  output  1  sticky flag: a byte was dropped.
- phase  output  2  current state encoding, for debug and test.

## Operation
- The FSM has four states:
  - S_A = 00: waiting for operand A.
  - S_B = 01: waiting for operand B.
  - S_OP = 10: waiting for the selector byte.
  - S_HOLD = 11: operand set held and offered to the consumer.
- S_A with wr_en: a_out <= data_in, go to S_B.
- S_B with wr_en: b_out <= data_in, go to S_OP.
- S_OP with wr_en: sel_out <= data_in[SEL_W-1:0], go to S_HOLD. data_in[7:SEL_W] is ignored.
- S_HOLD: op_valid = 1, and a_out, b_out and sel_out are frozen.
  - op_ready without wr_en: handshake completes, go to S_A.
  - op_ready with wr_en: handshake completes, a_out <= data_in, go to S_B. This overlaps consecutive operations.
  - wr_en without op_ready: the byte is dropped, ovf <= 1, state stays S_HOLD.
- wr_en low in S_A, S_B or S_OP: state holds.
- op_ready outside S_HOLD: ignored.
- clr, when rst is low:
  - state goes to S_A, op_valid goes to 0 and ovf goes to 0.
  - a_out, b_out and sel_out keep their values.
  - wr_en in the same cycle is ignored.
- Priority order: rst > clr > handshake/wr_en.
- Output definitions:
  - op_valid = (state == S_HOLD), registered through the state register.
  - busy = (state != S_A).
  - phase = state encoding.
- No arithmetic is done here. Values pass through unchanged.

## Timing
- Reset values: a_out = 0, b_out = 0, sel_out = 0, op_valid = 0, ovf = 0, busy = 0, phase = 00.
- Latency: op_valid rises in the cycle after the clock edge that samples the third wr_en.
- The minimum load time is 3 cycles. If wr_en is held high, the edges at cycles 0, 1 and 2 load A, B and the selector, and op_valid is high in cycle 3.
- Throughput: with op_ready tied high and wr_en continuous, one operand set completes every 3 cycles. The A load overlaps the handshake.
- op_valid falls in the cycle after the edge where op_valid and op_ready are both high, unless wr_en refilled A in that same edge; op_valid is 0 in S_B either way.
- Once op_valid is asserted, outputs do not change until the handshake edge or clr.
- ovf stays at 1 until rst or clr.
- rst in the middle of a load returns the block to the reset values on the next edge. clr in the middle of a load returns to S_A but keeps the operand values.

## Test plan
- Basic load: after rst, pulse wr_en with 0x3C, 0x05, 0x02 on consecutive cycles and hold op_ready low.
  - Required: op_valid = 1 in the 4th cycle, with a_out = 0x3C, b_out = 0x05, sel_out = 2 and phase = 11.
  - Then raise op_ready for one cycle. Required: op_valid = 0 and phase = 00.
- Selector masking: send 0xFF as the third byte. Required: sel_out = 3'b111 and a_out/b_out unchanged.
- Back-to-back: tie op_ready high and stream 6 bytes continuously (0x01, 0x02, 0x03, 0x04, 0x05, 0x06).
  - Required: op_valid is high in cycles 3 and 6.
  - Required: the second set shows a_out = 0x04, b_out = 0x05, sel_out = 6, and no ovf.
- Overflow: in S_HOLD with op_ready low, pulse wr_en with 0xAA.
  - Required: ovf = 1 and a_out unchanged.
  - Then pulse clr. Required: ovf = 0, phase = 00 and op_valid = 0.
- Abort: load A = 0x11 and B = 0x22, then pulse clr together with wr_en.
  - Required: phase = 00, a_out still 0x11, and the byte sent with clr is not captured.
- Reset mid-load: load A = 0x7F, then assert rst for one cycle. Required: all outputs at their reset values, including a_out = 0x00.
